// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : deser_pkg
//  Description : Shared definitions for the word deserializer: default
//                geometry, the fill-count width helper and the collector
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_ORDER = 0;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } deser_state_t;

    // Width needed to hold a word count in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : deser_out_reg
//  Description : Output holding register with valid/ready handshake. A load
//                strobe captures a frame and its word count; the contents stay
//                frozen until the consumer takes them.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_load        - capture i_frame/i_count this edge
//                i_frame       - frame to capture
//                i_count       - number of valid words in i_frame
//                i_ready       - consumer accepts the held frame
//                o_valid       - a frame is held
//                o_frame       - held frame
//                o_count       - held word count
//                o_free        - register can take a new frame this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module deser_out_reg #(
    parameter int FW = 64,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [FW-1:0] i_frame,
    input  logic [CW-1:0] i_count,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [FW-1:0] o_frame,
    output logic [CW-1:0] o_count,
    output logic          o_free
);

    logic          r_valid;
    logic [FW-1:0] r_frame;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_frame <= '0;
            r_count <= '0;
        end else if (i_load) begin
            // A load may coincide with the consumer taking the old frame.
            r_valid <= 1'b1;
            r_frame <= i_frame;
            r_count <= i_count;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_frame = r_frame;
    assign o_count = r_count;
    assign o_free  = !r_valid || i_ready;

endmodule
`default_nettype wire

// File: rtl/word_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_deserializer
//  Description : Packs WIDTH-bit input words into DEPTH-word frames. A flush
//                emits a partial frame (unused slots zero). ORDER selects
//                whether the first word lands in the lowest (0) or highest (1)
//                slot.
//  Ports       : clk, reset            - clock, asynchronous active-high reset
//                in_valid/in_ready     - input word handshake
//                in_data               - input word
//                flush                 - request emission of a partial frame
//                out_valid/out_ready   - output frame handshake
//                out_frame             - assembled frame, slot k at [k*WIDTH +: WIDTH]
//                out_count             - valid words in out_frame
//  Revision    : 1.0 - initial release
// ============================================================================
module word_deserializer
    import deser_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int ORDER = DEF_ORDER,
    localparam int CW    = cnt_width(DEPTH),
    localparam int FW    = WIDTH * DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FW-1:0]    out_frame,
    output logic [CW-1:0]    out_count
);

    deser_state_t  r_state;
    deser_state_t  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [FW-1:0] r_coll;
    logic [FW-1:0] w_coll_nxt;
    logic          r_flush_pend;
    logic          w_flush_pend_nxt;

    logic          w_accept;
    logic          w_free;
    logic          w_load;
    logic [FW-1:0] w_load_frame;
    logic [CW-1:0] w_load_count;
    logic [CW-1:0] w_slot;
    logic [CW-1:0] w_cnt_inc;
    logic [FW-1:0] w_coll_ins;

    // A pending flush blocks new words so the partial frame stays exactly
    // what was collected when the flush arrived.
    assign in_ready = (r_state == COLLECT) && !r_flush_pend;
    assign w_accept = in_valid && in_ready;

    // Only evaluated in COLLECT, where r_cnt < DEPTH keeps the slot in range.
    assign w_slot    = (ORDER == 0) ? r_cnt : (CW'(DEPTH - 1) - r_cnt);
    assign w_cnt_inc = r_cnt + {{(CW-1){1'b0}}, w_accept};

    // Collector contents including the word accepted on this edge.
    always_comb begin
        w_coll_ins = r_coll;
        if (w_accept) begin
            w_coll_ins[w_slot*WIDTH +: WIDTH] = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= COLLECT;
            r_cnt        <= '0;
            r_coll       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_coll       <= w_coll_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_coll_nxt       = r_coll;
        w_flush_pend_nxt = r_flush_pend;
        w_load           = 1'b0;
        w_load_frame     = w_coll_ins;
        w_load_count     = w_cnt_inc;

        case (r_state)
            COLLECT: begin
                if (w_cnt_inc == CW'(DEPTH)) begin
                    if (w_free) begin
                        w_load           = 1'b1;
                        w_cnt_nxt        = '0;
                        w_coll_nxt       = '0;
                        w_flush_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = w_cnt_inc;
                        w_coll_nxt  = w_coll_ins;
                    end
                end else if ((flush || r_flush_pend) && (w_cnt_inc != '0)) begin
                    if (w_free) begin
                        w_load           = 1'b1;
                        w_cnt_nxt        = '0;
                        w_coll_nxt       = '0;
                        w_flush_pend_nxt = 1'b0;
                    end else begin
                        w_flush_pend_nxt = 1'b1;
                        w_cnt_nxt        = w_cnt_inc;
                        w_coll_nxt       = w_coll_ins;
                    end
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_coll_nxt = w_coll_ins;
                end
            end
            HOLD: begin
                // No words are accepted here, so the defaults already carry
                // the full collector and a count of DEPTH.
                if (w_free) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_coll_nxt  = '0;
                    w_state_nxt = COLLECT;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    deser_out_reg #(
        .FW (FW),
        .CW (CW)
    ) u_out_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_frame (w_load_frame),
        .i_count (w_load_count),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_frame (out_frame),
        .o_count (out_count),
        .o_free  (w_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_word_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_deserializer
//  Description : Self-checking bench for word_deserializer (WIDTH=8, DEPTH=4).
//                Two instances share inputs: ORDER=0 and ORDER=1. Directed
//                steps followed by a random phase checked by a frame
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_deserializer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int FW = 32;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0;
    logic [FW-1:0] out_frame0;
    logic [CW-1:0] out_count0;
    logic          in_ready1, out_valid1;
    logic [FW-1:0] out_frame1;
    logic [CW-1:0] out_count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    word_deserializer #(.WIDTH(W), .DEPTH(D), .ORDER(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready0),
        .flush     (flush),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_frame (out_frame0),
        .out_count (out_count0)
    );

    word_deserializer #(.WIDTH(W), .DEPTH(D), .ORDER(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready1),
        .flush     (flush),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_frame (out_frame1),
        .out_count (out_count1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Transaction-level scoreboard, sampled on the falling edge with the
    // values the DUT will register at the next rising edge.
    // ------------------------------------------------------------------
    logic [FW-1:0] q_f0[$];
    logic [FW-1:0] q_f1[$];
    logic [CW-1:0] q_c[$];
    logic [FW-1:0] m_f0 = '0;
    logic [FW-1:0] m_f1 = '0;
    int            m_cnt = 0;
    logic          prev_hold = 1'b0;
    logic [FW-1:0] prev_f = '0;

    always @(negedge clk) begin
        if (reset) begin
            q_f0.delete();
            q_f1.delete();
            q_c.delete();
            m_f0      = '0;
            m_f1      = '0;
            m_cnt     = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", out_frame0, prev_f);
            if (out_valid0 && out_ready) begin
                if (q_c.size() == 0) begin
                    chk("sb_spurious_frame", out_count0, 0);
                end else begin
                    chk("sb_frame_ord0", out_frame0, q_f0[0]);
                    chk("sb_frame_ord1", out_frame1, q_f1[0]);
                    chk("sb_count", out_count0, q_c[0]);
                    void'(q_f0.pop_front());
                    void'(q_f1.pop_front());
                    void'(q_c.pop_front());
                end
            end
            if (in_valid && in_ready0) begin
                m_f0[m_cnt*W +: W]       = in_data;
                m_f1[(D-1-m_cnt)*W +: W] = in_data;
                m_cnt++;
            end
            if (m_cnt == D || (flush && m_cnt > 0)) begin
                q_f0.push_back(m_f0);
                q_f1.push_back(m_f1);
                q_c.push_back(CW'(m_cnt));
                m_f0  = '0;
                m_f1  = '0;
                m_cnt = 0;
            end
            prev_hold = out_valid0 && !out_ready;
            prev_f    = out_frame0;
        end
    end

    initial begin
        // Reset state, visible without a clock edge.
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_frame", out_frame0, 0);
        chk("rst_out_count", out_count0, 0);
        tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready0, 1);

        // Full frame back-to-back, latency of one cycle.
        out_ready = 1'b1;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        chk("t1_no_early_valid", out_valid0, 0);
        send(8'h44);
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid0, 1);
        chk("t1_frame_ord0", out_frame0, 32'h44332211);
        chk("t1_frame_ord1", out_frame1, 32'h11223344);
        chk("t1_count", out_count0, 4);
        tick();
        chk("t1_valid_drop", out_valid0, 0);

        // Back-pressure: second frame waits in HOLD.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(W'(i));
        in_valid = 1'b0;
        chk("t2_hold_in_ready", in_ready0, 0);
        chk("t2_first_frame", out_frame0, 32'h04030201);
        tick();
        chk("t2_first_stable", out_frame0, 32'h04030201);
        chk("t2_still_valid", out_valid0, 1);
        out_ready = 1'b1;
        tick();
        chk("t2_second_frame", out_frame0, 32'h08070605);
        chk("t2_second_valid", out_valid0, 1);
        chk("t2_ready_back", in_ready0, 1);
        tick();
        chk("t2_valid_drop", out_valid0, 0);

        // Flush with a word accepted on the same edge.
        send(8'hAA);
        send(8'hBB);
        flush = 1'b1;
        send(8'hCC);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t3_partial_ord0", out_frame0, 32'h00CCBBAA);
        chk("t3_partial_ord1", out_frame1, 32'hAABBCC00);
        chk("t3_partial_count", out_count0, 3);
        tick();
        chk("t3_valid_drop", out_valid0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_empty_flush", out_valid0, 0);
        tick();
        chk("t3_empty_flush_late", out_valid0, 0);

        // Flush pending while the output register is occupied.
        out_ready = 1'b0;
        send(8'h01);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_single_ord0", out_frame0, 32'h00000001);
        chk("t4_single_ord1", out_frame1, 32'h01000000);
        chk("t4_single_count", out_count0, 1);
        send(8'h02);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_pend_in_ready", in_ready0, 0);
        chk("t4_pend_old_frame", out_frame0, 32'h00000001);
        tick();
        chk("t4_pend_in_ready2", in_ready0, 0);
        out_ready = 1'b1;
        tick();
        chk("t4_pend_frame", out_frame0, 32'h00000002);
        chk("t4_pend_count", out_count0, 1);
        chk("t4_ready_back", in_ready0, 1);
        tick();
        chk("t4_valid_drop", out_valid0, 0);

        // Asynchronous reset mid-frame with a frame held.
        out_ready = 1'b0;
        send(8'h10);
        send(8'h11);
        send(8'h12);
        send(8'h13);
        send(8'h20);
        send(8'h21);
        in_valid = 1'b0;
        chk("t5_valid_before", out_valid0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_valid", out_valid0, 0);
        chk("t5_async_frame", out_frame0, 0);
        chk("t5_async_count", out_count0, 0);
        tick();
        reset = 1'b0;
        chk("t5_in_ready", in_ready0, 1);
        out_ready = 1'b1;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        send(8'h34);
        in_valid = 1'b0;
        chk("t5_clean_frame", out_frame0, 32'h34333231);
        chk("t5_clean_count", out_count0, 4);
        tick();

        // Random traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("drain_empty", q_c.size(), 0);
        chk("drain_idle", out_valid0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
